// File: rtl/riscv_irq_ctrl_if.sv
// Word-addressed register bus shared with the LSU/ext_mem path.
// The master drives the request side; the slave returns registered rd/ready.
interface riscv_irq_ctrl_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;

  modport master (output req, we, be, addr, wd, input  rd, ready);
  modport slave  (input  req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/riscv_irq_ctrl.sv
// Interrupt controller: latches source events, masks/prioritises them and holds one request until mret.
// Optional macro IRQ_LEVEL_MODE_EN adds a LEVEL register for level-sensitive sources.
module riscv_irq_ctrl #(
  parameter int N_SRC      = 16,
  parameter int CAUSE_BASE = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] irq_src_i,
  output logic             irq_req_o,
  input  logic             irq_ret_i,
  output logic [31:0]      irq_cause_o,
  riscv_irq_ctrl_if.slave  mem
);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] pending_q, mask_q, prev_q, level_q;
  logic             en_q;
  logic [IW-1:0]    idx_q, idx_d;
  logic [31:0]      cause_q;

  logic [N_SRC-1:0] armed, set_vec, clr_vec, ret_vec, bm;
  logic [31:0]      bm32, rdata;
  logic [2:0]       sel;
  logic             wr, ret_fire, take;

  assign sel      = mem.addr[4:2];
  assign wr       = mem.req & mem.we;
  assign bm32     = {{8{mem.be[3]}}, {8{mem.be[2]}}, {8{mem.be[1]}}, {8{mem.be[0]}}};
  assign bm       = bm32[N_SRC-1:0];
  assign armed    = pending_q & mask_q;
  assign ret_fire = (state_q == ACTIVE) && irq_ret_i;

  logic unused_bits;
  assign unused_bits = ^{mem.addr[31:5], mem.addr[1:0], mem.wd[31:N_SRC], bm32[31:N_SRC]};

  // Lowest-numbered armed source wins.
  always_comb begin
    idx_d = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (armed[i]) idx_d = IW'(i);
  end

  always_comb begin
    ret_vec = '0;
    if (ret_fire) ret_vec[idx_q] = 1'b1;
  end

  assign clr_vec = ret_vec | ((wr && sel == 3'd0) ? (mem.wd[N_SRC-1:0] & bm) : '0);

`ifdef IRQ_LEVEL_MODE_EN
  // Level sources skip the ret cycle so the handler sees the clear before re-assertion.
  assign set_vec = (irq_src_i & ~prev_q & ~level_q) | (irq_src_i & level_q & ~ret_vec);
`else
  assign set_vec = irq_src_i & ~prev_q;
  assign level_q = '0;
`endif

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IDLE:   if (en_q && |armed) begin state_d = ACTIVE; take = 1'b1; end
      ACTIVE: if (irq_ret_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    irq_req_o   = (state_q == ACTIVE);
    irq_cause_o = cause_q;
  end

  // Set terms are OR'd after the clear so a same-cycle rise always survives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      prev_q    <= '0;
      idx_q     <= '0;
      cause_q   <= '0;
    end else begin
      prev_q    <= irq_src_i;
      pending_q <= (pending_q & ~clr_vec) | set_vec;
      if (take) begin
        idx_q   <= idx_d;
        cause_q <= {1'b1, 26'b0, 5'(CAUSE_BASE) + 5'(idx_d)};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q <= '0;
      en_q   <= 1'b0;
    end else if (wr) begin
      if (sel == 3'd1) mask_q <= (mask_q & ~bm) | (mem.wd[N_SRC-1:0] & bm);
      if (sel == 3'd3 && mem.be[0]) en_q <= mem.wd[0];
    end
  end

`ifdef IRQ_LEVEL_MODE_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                   level_q <= '0;
    else if (wr && sel == 3'd4)  level_q <= (level_q & ~bm) | (mem.wd[N_SRC-1:0] & bm);
  end
`endif

  always_comb begin
    rdata = '0;
    case (sel)
      3'd0: rdata = 32'(pending_q);
      3'd1: rdata = 32'(mask_q);
      3'd2: rdata = cause_q;
      3'd3: rdata = {31'b0, en_q};
`ifdef IRQ_LEVEL_MODE_EN
      3'd4: rdata = 32'(level_q);
`endif
      default: rdata = '0;
    endcase
  end

  // Read data is captured at the request edge, before any same-edge write lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem.rd    <= '0;
      mem.ready <= 1'b0;
    end else begin
      mem.rd    <= (mem.req && !mem.we) ? rdata : '0;
      mem.ready <= mem.req;
    end
  end
endmodule
